// File: rtl/pri_enc_pkg.sv
// Shared constants and helpers for the pri_encoder_sched block.
// Index width, count width and the pending population count all come from here.
package pri_enc_pkg;

  localparam int PRI_ENC_MAX_N = 64;

  // Smallest r with 2**r >= value; used for index and count widths.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      result = ((32'sd1 <<< i) < value) ? (i + 1) : result;
    end
    return result;
  endfunction

  function automatic logic [6:0] popcount(input logic [PRI_ENC_MAX_N-1:0] vec);
    logic [6:0] total;
    total = 7'd0;
    for (int i = 0; i < PRI_ENC_MAX_N; i++) begin
      total = total + {6'd0, vec[i]};
    end
    return total;
  endfunction

endpackage

// File: rtl/pri_encoder_core.sv
// Combinational wrap-around priority search: start, start-1, ..., 0, N-1, ...
// The first set bit of vec met in that order is reported on idx.
module pri_encoder_core
  import pri_enc_pkg::*;
#(
  parameter int N = 8,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan from the lowest priority offset up, so the highest-priority hit is written last.
  always_comb begin
    int pos;
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int off = N - 1; off >= 0; off--) begin
      pos = int'(start) - off;
      pos = (pos < 0) ? (pos + N) : pos;
      idx = vec[pos] ? W'(pos) : idx;
      any = any | vec[pos];
    end
  end

endmodule

// File: rtl/pri_encoder_sched.sv
// Registered request scheduler: latches req into pending, offers the winner on valid/ready.
// Define PRI_ENC_RR_EN for round-robin priority; otherwise index N-1 always wins.
module pri_encoder_sched
  import pri_enc_pkg::*;
#(
  parameter int N = 8,
  localparam int W = clog2(N),
  localparam int CW = clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [N-1:0]  req,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_idx,
  output logic [N-1:0]  pending,
  output logic [CW-1:0] pend_cnt,
  output logic          dup
);

  logic [W-1:0] start;
  logic [W-1:0] grant_idx;
  logic         grant_any;
  logic         fire;
  logic [N-1:0] clr;
  logic [N-1:0] pending_next;
  logic         dup_next;

  pri_encoder_core #(.N(N)) u_core (
    .vec   (pending),
    .start (start),
    .idx   (grant_idx),
    .any   (grant_any)
  );

`ifdef PRI_ENC_RR_EN
  logic [W-1:0] ptr;

  // Pointer moves just below the granted index so it gets lowest priority next.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= W'(N - 1);
    end else if (fire) begin
      ptr <= (out_idx == {W{1'b0}}) ? W'(N - 1) : (out_idx - {{(W-1){1'b0}}, 1'b1});
    end else begin
      ptr <= ptr;
    end
  end

  assign start = ptr;
`else
  assign start = W'(N - 1);
`endif

  // Offer and count; en low hides the offer without touching pending.
  always_comb begin
    out_valid = en & grant_any;
    out_idx   = out_valid ? grant_idx : {W{1'b0}};
    pend_cnt  = CW'(popcount(PRI_ENC_MAX_N'(pending)));
    fire      = out_valid & out_ready;
  end

  // Clear the granted bit, merge new requests and flag collisions with untouched bits.
  always_comb begin
    clr = {N{1'b0}};
    if (fire) begin
      clr = {{(N-1){1'b0}}, 1'b1} << out_idx;
    end else begin
      clr = {N{1'b0}};
    end
    pending_next = (pending & ~clr) | req;
    dup_next     = en & (|(req & pending & ~clr));
  end

  // Pending state and the registered duplicate pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= {N{1'b0}};
      dup     <= 1'b0;
    end else if (en) begin
      pending <= pending_next;
      dup     <= dup_next;
    end else begin
      pending <= pending;
      dup     <= 1'b0;
    end
  end

endmodule
